// File: rtl/dct_block_loader.sv
// Pixel-to-block loader ahead of DCT1D: converts 8-bit pixels to fixed point,
// assembles 8x8 blocks in a ping-pong buffer and steps DCT1D through clk_cnt.
module dct_block_loader #(
  parameter int PIX_W     = 8,
  parameter int DATA_W    = 24,
  parameter int FRAC_W    = 8,
  parameter int N         = 64,
  parameter int HOLD      = 5,
  parameter int LVL_SHIFT = 0,
  parameter int CNT_W     = (HOLD > 15) ? $clog2(HOLD + 1) : 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_W-1:0]      pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [N*DATA_W-1:0]   blk_data,
  output logic                  blk_valid,
  output logic [CNT_W-1:0]      clk_cnt
);

  localparam int FILL_W = $clog2(N);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Pixel -> signed fixed point, optionally centred on zero by removing 2^(PIX_W-1).
  function automatic logic signed [DATA_W-1:0] to_fixed(input logic [PIX_W-1:0] pix);
    logic signed [PIX_W:0]    s;
    logic signed [DATA_W-1:0] ext;
    if (LVL_SHIFT != 0)
      s = $signed({1'b0, pix}) - $signed({2'b01, {(PIX_W-1){1'b0}}});
    else
      s = $signed({1'b0, pix});
    ext = {{(DATA_W-PIX_W-1){s[PIX_W]}}, s};
    return ext <<< FRAC_W;
  endfunction

  logic [N*DATA_W-1:0] bank_q [2];
  logic [1:0]          full_q, full_d;
  logic                wr_bank_q, wr_bank_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                rd_bank_q;
  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                blk_valid_q;
  logic [N*DATA_W-1:0] blk_data_q;
  logic                accept;
  logic                release_blk;

  assign pix_ready   = !full_q[wr_bank_q];
  assign accept      = pix_valid && pix_ready;
  assign release_blk = (state_q == RUN) && (cnt_q == CNT_W'(HOLD));

  assign blk_data  = blk_data_q;
  assign blk_valid = blk_valid_q;
  assign clk_cnt   = cnt_q;

  // Write side: fill counter, bank select and full flags (set on fill, cleared on release).
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    fill_d    = fill_q;
    if (release_blk)
      full_d[rd_bank_q] = 1'b0;
    if (accept) begin
      if (fill_q == FILL_W'(N - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        fill_d            = '0;
      end else begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      fill_q    <= '0;
      bank_q[0] <= '0;
      bank_q[1] <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      fill_q    <= fill_d;
      if (accept)
        bank_q[wr_bank_q][fill_q*DATA_W +: DATA_W] <= to_fixed(pix_in);
    end
  end

  // Output FSM: the block is copied out on RUN entry so blk_data survives later refills.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      cnt_q       <= '0;
      blk_valid_q <= 1'b0;
      blk_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q     <= RUN;
            cnt_q       <= CNT_W'(1);
            blk_valid_q <= 1'b1;
            blk_data_q  <= bank_q[rd_bank_q];
          end
        end
        RUN: begin
          if (!release_blk) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            rd_bank_q <= ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              cnt_q      <= CNT_W'(1);
              blk_data_q <= bank_q[~rd_bank_q];
            end else begin
              state_q     <= IDLE;
              cnt_q       <= '0;
              blk_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          blk_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_block_loader.sv
// Bench for dct_block_loader: two builds (HOLD=5 plain, HOLD=64 level-shifted) share one
// pixel stream; a block-level reference model feeds per-DUT scoreboards.
module tb_dct_block_loader;

  localparam int N  = 64;
  localparam int DW = 24;
  localparam int BW = N * DW;
  localparam int HOLD_OF [2] = '{5, 64};

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          rdy_a, rdy_b, val_a, val_b;
  logic [BW-1:0] dat_a, dat_b;
  logic [3:0]    cnt_a;
  logic [6:0]    cnt_b;

  always #5 clk = ~clk;

  dct_block_loader #(.HOLD(5), .LVL_SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy_a),
    .blk_data(dat_a), .blk_valid(val_a), .clk_cnt(cnt_a));

  dct_block_loader #(.HOLD(64), .LVL_SHIFT(1)) dut_b (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy_b),
    .blk_data(dat_b), .blk_valid(val_b), .clk_cnt(cnt_b));

  int            n_checks = 0;
  int            n_errors = 0;
  int            d_cnt [2];
  logic          d_val [2], d_rdy [2];
  logic [BW-1:0] d_dat [2];

  always_comb begin
    d_cnt[0] = int'(cnt_a); d_cnt[1] = int'(cnt_b);
    d_val[0] = val_a;       d_val[1] = val_b;
    d_rdy[0] = rdy_a;       d_rdy[1] = rdy_b;
    d_dat[0] = dat_a;       d_dat[1] = dat_b;
  end

  function automatic logic [23:0] ref_conv(input int pix, input bit lvl);
    int v;
    v = lvl ? (pix - 128) * 256 : pix * 256;
    return v[23:0];
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      for (int k = 0; k < N; k++)
        if (act[k*DW +: DW] != exp[k*DW +: DW]) begin
          $display("FAIL %s: element %0d got %h expected %h at %0t",
                   nm, k, act[k*DW +: DW], exp[k*DW +: DW], $time);
          break;
        end
    end
  endtask

  // Reference model: counts completed-but-unreleased blocks and the step counter.
  int            m_out [2]  = '{0, 0};
  int            m_cnt [2]  = '{0, 0};
  int            m_fill [2] = '{0, 0};
  bit            m_rst [2]  = '{0, 0};
  logic [BW-1:0] m_cur [2];
  logic [BW-1:0] q0 [$];
  logic [BW-1:0] q1 [$];
  bit            mon_en = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_out[i] = 0; m_cnt[i] = 0; m_fill[i] = 0; m_rst[i] = 1;
        if (i == 0) q0.delete(); else q1.delete();
        mon_en = 1;
      end else begin
        int  old, inc;
        bit  rel;
        m_rst[i] = 0;
        old = m_out[i];
        inc = 0;
        rel = (m_cnt[i] == HOLD_OF[i]);
        if (pix_valid && old < 2) begin
          m_cur[i][m_fill[i]*DW +: DW] = ref_conv(int'(pix_in), i == 1);
          if (m_fill[i] == N - 1) begin
            if (i == 0) q0.push_back(m_cur[i]); else q1.push_back(m_cur[i]);
            m_fill[i] = 0;
            inc = 1;
          end else begin
            m_fill[i]++;
          end
        end
        if (m_cnt[i] == 0)  m_cnt[i] = (old > 0) ? 1 : 0;
        else if (!rel)      m_cnt[i]++;
        else                m_cnt[i] = (old == 2) ? 1 : 0;
        m_out[i] = old - (rel ? 1 : 0) + inc;
      end
    end
  end

  // Monitor: per-cycle control checks, block pop on clk_cnt==1, stability during RUN.
  logic [BW-1:0] last_dat [2];
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        string tag;
        tag = (i == 0) ? "a" : "b";
        chk({"clk_cnt_", tag}, d_cnt[i], m_cnt[i]);
        chk({"blk_valid_", tag}, d_val[i], m_cnt[i] != 0);
        chk({"pix_ready_", tag}, d_rdy[i], m_out[i] < 2);
        if (m_rst[i])
          chk_blk({"reset_data_", tag}, d_dat[i], '0);
        if (d_val[i] && d_cnt[i] == 1) begin
          logic [BW-1:0] e;
          bit            have;
          have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
          chk({"blk_pop_", tag}, have, 1);
          if (have) begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk_blk({"blk_data_", tag}, d_dat[i], e);
          end
          last_dat[i] = d_dat[i];
        end else if (d_val[i] && d_cnt[i] > 1) begin
          chk_blk({"blk_stable_", tag}, d_dat[i], last_dat[i]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] p, input bit v);
    pix_in    = p;
    pix_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cnt_a(input int target, input int budget);
    int t;
    t = 0;
    while (int'(cnt_a) != target && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_clk_cnt_a", int'(cnt_a), target);
  endtask

  logic [7:0] dir [5] = '{8'd130, 8'd132, 8'd0, 8'd128, 8'd255};

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", rdy_a, 1);
    chk("rst_valid", val_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_data_zero", (dat_a == '0) && (dat_b == '0), 1);

    // Single block with known leading pixels.
    for (int k = 0; k < N; k++)
      send((k < 5) ? dir[k] : 8'($urandom_range(0, 255)), 1'b1);
    pix_valid = 1'b0;
    wait_cnt_a(1, 10);
    chk("a_elem0", dat_a[0*DW +: DW], 24'h008200);
    chk("a_elem1", dat_a[1*DW +: DW], 24'h008400);
    chk("b_elem0", dat_b[0*DW +: DW], 24'h000200);
    chk("b_elem1", dat_b[1*DW +: DW], 24'h000400);
    chk("b_elem2", dat_b[2*DW +: DW], 24'hFF8000);
    chk("b_elem3", dat_b[3*DW +: DW], 24'h000000);
    chk("b_elem4", dat_b[4*DW +: DW], 24'h007F00);
    idle(80);

    // Continuous stream, then bursty stream.
    for (int k = 0; k < 192; k++) send(8'($urandom_range(0, 255)), 1'b1);
    for (int k = 0; k < 200; k++) send(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
    idle(140);

    // Reset mid-block, then mid-RUN.
    for (int k = 0; k < 30; k++) send(8'($urandom_range(0, 255)), 1'b1);
    rst = 1'b1;
    send(8'd0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < N; k++) send(8'($urandom_range(0, 255)), 1'b1);
    pix_valid = 1'b0;
    wait_cnt_a(3, 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrun_rst_cnt_a", cnt_a, 0);
    chk("midrun_rst_valid_a", val_a, 0);
    chk("midrun_rst_cnt_b", cnt_b, 0);

    // Fresh block after reset.
    for (int k = 0; k < N; k++) send(8'($urandom_range(0, 255)), 1'b1);
    idle(140);
    chk("sb_empty_a", q0.size(), 0);
    chk("sb_empty_b", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
